dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between two requesters: the CPU execute stage and a DMA/debug loader port. The CPU has default priority. A starvation counter guarantees that DMA gets forward progress. DMA can lock a bounded burst, after which the CPU is guaranteed one yield slot. The block sits between the execute-stage memory signals and the data memory. It drives a stall back to the pipeline whenever the CPU is denied.

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates a single-port data memory between the CPU execute stage and a
// DMA/debug loader port. The CPU has priority by default. A starvation counter
// forces a DMA win after STARVE_LIMIT consecutive denied DMA cycles. DMA may
// lock a burst of up to MAX_BURST beats, and the CPU then gets one yield slot.
//
// Optional build macro: ARB_STATS_EN adds saturating 16-bit statistics
// outputs cpu_stall_count and dma_grant_count.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request side
//   cpu_gnt, cpu_stall              combinational grant / pipeline stall
//   cpu_rdata, cpu_rvalid           registered read data + 1-cycle valid pulse
//   dma_req/lock/we/addr/wdata      DMA request side
//   dma_gnt                         combinational grant
//   dma_rdata, dma_rvalid           registered read data + 1-cycle valid pulse
//   mem_write/address/datain        to data memory (zero when idle)
//   mem_dataout                     combinational read data from data memory
module dmem_arbiter #(
   parameter int DW           = 8,
   parameter int AW           = 8,
   parameter int MAX_BURST    = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          dma_req,
   input  logic          dma_lock,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic          mem_write,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]   cpu_stall_count,
   output logic [15:0]   dma_grant_count
`endif
);

   // beat counter gets one spare value so the incremented count never wraps
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(MAX_BURST + 2);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BURST);

   typedef enum logic [1:0] {ARB, BURST, YIELD} state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
   logic [BW-1:0] beat_cnt_reg, beat_cnt_next, beat_inc;
   logic [DW-1:0] cpu_rdata_reg, dma_rdata_reg;
   logic          cpu_rvalid_reg, dma_rvalid_reg;

   assign beat_inc = beat_cnt_reg + BW'(1);

   // grant decision and next state
   always_comb begin
      cpu_gnt       = 1'b0;
      dma_gnt       = 1'b0;
      state_next    = state_reg;
      beat_cnt_next = beat_cnt_reg;
      case (state_reg)
         ARB: begin
            dma_gnt = dma_req & (~cpu_req | (starve_cnt_reg >= STARVE_MAX));
            cpu_gnt = cpu_req & ~dma_gnt;
            // the ARB-state grant is the first beat of a locked burst
            if (dma_gnt && dma_lock) begin
               state_next    = BURST;
               beat_cnt_next = BW'(1);
            end
         end
         BURST: begin
            dma_gnt = dma_req;
            // an unlocked request this cycle is still granted, then the burst ends
            if (!dma_req || !dma_lock || (beat_inc >= BEAT_MAX)) begin
               state_next    = cpu_req ? YIELD : ARB;
               beat_cnt_next = '0;
            end else begin
               beat_cnt_next = beat_inc;
            end
         end
         YIELD: begin
            cpu_gnt    = cpu_req;
            state_next = ARB;
         end
         default: begin
            state_next    = ARB;
            beat_cnt_next = '0;
         end
      endcase
   end

   // starvation counter: saturating count of consecutive denied DMA cycles
   always_comb begin
      starve_cnt_next = '0;
      if (dma_req && !dma_gnt) begin
         starve_cnt_next = (starve_cnt_reg >= STARVE_MAX) ? STARVE_MAX
                                                          : starve_cnt_reg + SW'(1);
      end
   end

   // memory mux: idle bus is all zeros
   always_comb begin
      mem_write   = 1'b0;
      mem_address = '0;
      mem_datain  = '0;
      if (cpu_gnt) begin
         mem_write   = cpu_we;
         mem_address = cpu_addr;
         mem_datain  = cpu_wdata;
      end else if (dma_gnt) begin
         mem_write   = dma_we;
         mem_address = dma_addr;
         mem_datain  = dma_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ARB;
         starve_cnt_reg <= '0;
         beat_cnt_reg   <= '0;
         cpu_rdata_reg  <= '0;
         dma_rdata_reg  <= '0;
         cpu_rvalid_reg <= 1'b0;
         dma_rvalid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
         beat_cnt_reg   <= beat_cnt_next;
         cpu_rvalid_reg <= cpu_gnt & ~cpu_we;
         dma_rvalid_reg <= dma_gnt & ~dma_we;
         if (cpu_gnt && !cpu_we) cpu_rdata_reg <= mem_dataout;
         if (dma_gnt && !dma_we) dma_rdata_reg <= mem_dataout;
      end
   end

   assign cpu_stall  = cpu_req & ~cpu_gnt;
   assign cpu_rdata  = cpu_rdata_reg;
   assign cpu_rvalid = cpu_rvalid_reg;
   assign dma_rdata  = dma_rdata_reg;
   assign dma_rvalid = dma_rvalid_reg;

`ifdef ARB_STATS_EN
   logic [15:0] cpu_stall_count_reg, dma_grant_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_stall_count_reg <= '0;
         dma_grant_count_reg <= '0;
      end else begin
         if (cpu_stall && (cpu_stall_count_reg != 16'hFFFF))
            cpu_stall_count_reg <= cpu_stall_count_reg + 16'd1;
         if (dma_gnt && (dma_grant_count_reg != 16'hFFFF))
            dma_grant_count_reg <= dma_grant_count_reg + 16'd1;
      end
   end

   assign cpu_stall_count = cpu_stall_count_reg;
   assign dma_grant_count = dma_grant_count_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, a flag-based behavioural model
// checked on every cycle outside reset, plus literal expectations per scenario.
module tb_dmem_arbiter;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int MAX_BURST = 4;
   localparam int STARVE_LIMIT = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_datain, mem_dataout;
`ifdef ARB_STATS_EN
   logic [15:0]   cpu_stall_count, dma_grant_count;
`endif

   dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_write(mem_write), .mem_address(mem_address), .mem_datain(mem_datain),
      .mem_dataout(mem_dataout)
`ifdef ARB_STATS_EN
      , .cpu_stall_count(cpu_stall_count), .dma_grant_count(dma_grant_count)
`endif
   );

   always #5 clk = ~clk;

   // the data memory the arbiter drives, and the model's copy of it
   logic [DW-1:0] tb_mem  [256];
   logic [DW-1:0] ref_mem [256];
   assign mem_dataout = tb_mem[mem_address];
   always @(posedge clk) if (mem_write) tb_mem[mem_address] <= mem_datain;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   bit quiet = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_starve;   // consecutive cycles DMA has waited
   bit            m_burst;    // DMA owns the memory in a locked burst
   int            m_beats;    // beats already taken in the current burst
   bit            m_yield;    // CPU is owed its one slot this cycle
   bit            m_cpu_rvalid, m_dma_rvalid;
   logic [DW-1:0] m_cpu_rdata, m_dma_rdata;
   int            m_stall_cnt, m_dgnt_cnt;

   function automatic void expect_gnt(output bit ec, output bit ed);
      if (m_yield) begin
         ec = cpu_req; ed = 1'b0;
      end else if (m_burst) begin
         ec = 1'b0; ed = dma_req;
      end else begin
         ed = dma_req && (!cpu_req || m_starve >= STARVE_LIMIT);
         ec = cpu_req && !ed;
      end
   endfunction

   always @(posedge clk) begin
      bit ec, ed;
      int nb;
      if (reset) begin
         m_starve <= 0; m_burst <= 1'b0; m_beats <= 0; m_yield <= 1'b0;
         m_cpu_rvalid <= 1'b0; m_dma_rvalid <= 1'b0;
         m_cpu_rdata <= '0; m_dma_rdata <= '0;
         m_stall_cnt <= 0; m_dgnt_cnt <= 0;
      end else begin
         expect_gnt(ec, ed);
         m_cpu_rvalid <= ec && !cpu_we;
         m_dma_rvalid <= ed && !dma_we;
         if (ec && !cpu_we) m_cpu_rdata <= ref_mem[cpu_addr];
         if (ed && !dma_we) m_dma_rdata <= ref_mem[dma_addr];
         if (ec && cpu_we) ref_mem[cpu_addr] <= cpu_wdata;
         if (ed && dma_we) ref_mem[dma_addr] <= dma_wdata;
         if (cpu_req && !ec && m_stall_cnt < 65535) m_stall_cnt <= m_stall_cnt + 1;
         if (ed && m_dgnt_cnt < 65535) m_dgnt_cnt <= m_dgnt_cnt + 1;
         m_starve <= (dma_req && !ed) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
         if (m_yield) begin
            m_yield <= 1'b0;
         end else if (m_burst) begin
            nb = m_beats + (dma_req ? 1 : 0);
            if (!dma_req || !dma_lock || nb >= MAX_BURST) begin
               m_burst <= 1'b0; m_beats <= 0; m_yield <= cpu_req;
            end else begin
               m_beats <= nb;
            end
         end else if (ed && dma_lock) begin
            m_burst <= 1'b1; m_beats <= 1;
         end
      end
   end

   // compare process: every cycle outside reset
   always @(negedge clk) begin
      bit ec, ed;
      if (chk_on && !reset) begin
         expect_gnt(ec, ed);
         check("cpu_gnt", cpu_gnt, ec);
         check("dma_gnt", dma_gnt, ed);
         check("cpu_stall", cpu_stall, cpu_req && !ec);
         check("mem_write", mem_write, ec ? cpu_we : (ed ? dma_we : 1'b0));
         check("mem_address", mem_address, ec ? cpu_addr : (ed ? dma_addr : '0));
         check("mem_datain", mem_datain, ec ? cpu_wdata : (ed ? dma_wdata : '0));
         check("cpu_rvalid", cpu_rvalid, m_cpu_rvalid);
         check("dma_rvalid", dma_rvalid, m_dma_rvalid);
         check("cpu_rdata", cpu_rdata, m_cpu_rdata);
         check("dma_rdata", dma_rdata, m_dma_rdata);
`ifdef ARB_STATS_EN
         check("cpu_stall_count", cpu_stall_count, m_stall_cnt);
         check("dma_grant_count", dma_grant_count, m_dgnt_cnt);
`endif
         if (!quiet && (cpu_gnt || dma_gnt))
            $display("txn t=%0t %s %s addr=%02h wdata=%02h", $time, cpu_gnt ? "cpu" : "dma",
                     mem_write ? "wr" : "rd", mem_address, mem_datain);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // drive one cycle of requests and check the grants against literals
   task automatic apply(input string nm, input bit cr, input bit dr, input bit dl,
                        input bit exp_c, input bit exp_d);
      cpu_req = cr; dma_req = dr; dma_lock = dl;
      at_neg();
      check({nm, ".cpu_gnt"}, cpu_gnt, exp_c);
      check({nm, ".dma_gnt"}, dma_gnt, exp_d);
      tick();
   endtask

   initial begin
      int da;
      bit g;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  <= 8'(i) ^ 8'h5A;
         ref_mem[i] <= 8'(i) ^ 8'h5A;
      end
      tb_mem[8'h10]  <= 8'hA5;
      ref_mem[8'h10] <= 8'hA5;
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      tick(); tick();
      at_neg();
      check("reset.cpu_rvalid", cpu_rvalid, 1'b0);
      check("reset.dma_rvalid", dma_rvalid, 1'b0);
      check("reset.cpu_rdata", cpu_rdata, 8'h00);
      check("reset.dma_rdata", dma_rdata, 8'h00);
      check("reset.idle_bus", {mem_write, mem_address, mem_datain}, 17'h0);
      tick();
      reset = 1'b0;
      chk_on = 1'b1;

      // CPU-only read of 0x10
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      at_neg();
      check("cpurd.gnt", cpu_gnt, 1'b1);
      tick();
      cpu_req = 0;
      at_neg();
      check("cpurd.rvalid", cpu_rvalid, 1'b1);
      check("cpurd.rdata", cpu_rdata, 8'hA5);
      check("cpurd.dma_rvalid", dma_rvalid, 1'b0);
      tick();

      // continuous contention, no lock: CPU x3 then DMA, repeating
      cpu_addr = 8'h11; dma_addr = 8'h12; dma_we = 0;
      for (int i = 0; i < 8; i++) begin
         cpu_req = 1; dma_req = 1; dma_lock = 0;
         at_neg();
         check("starve.dma_gnt", dma_gnt, (i % 4) == 3);
         check("starve.cpu_stall", cpu_stall, (i % 4) == 3);
         tick();
      end
      cpu_req = 0; dma_req = 0;
      tick();

      // locked DMA writes to 0..5 while CPU keeps requesting
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      dma_lock = 1; dma_we = 1;
      da = 0;
      for (int c = 0; c < 20; c++) begin
         dma_req = (da < 6); dma_addr = AW'(da); dma_wdata = DW'(8'hC0 + da);
         at_neg();
         g = dma_gnt;
         if (c < 8) check("burst.dma_gnt", dma_gnt, (c >= 3 && c <= 6));
         if (c == 7) check("burst.yield_cpu", cpu_gnt, 1'b1);
         tick();
         if (g) da++;
      end
      check("burst.beats_done", da, 6);
      cpu_req = 0; dma_req = 0; dma_lock = 0; dma_we = 0;
      tick();

      // read back the burst data through the CPU port
      cpu_req = 1; cpu_addr = 8'h00;
      tick();
      for (int a = 1; a <= 6; a++) begin
         if (a < 6) cpu_addr = AW'(a); else cpu_req = 0;
         at_neg();
         check("readback.rvalid", cpu_rvalid, 1'b1);
         check("readback.rdata", cpu_rdata, DW'(8'hC0 + a - 1));
         tick();
      end

      // lock dropped after 2 beats, CPU idle -> back to ARB
      dma_addr = 8'h30;
      apply("unlock_arb.b1", 0, 1, 1, 0, 1);
      apply("unlock_arb.b2", 0, 1, 1, 0, 1);
      apply("unlock_arb.exit", 0, 1, 0, 0, 1);
      apply("unlock_arb.arb", 0, 1, 0, 0, 1);
      apply("idle", 0, 0, 0, 0, 0);
      // lock dropped after 2 beats, CPU requesting -> YIELD
      apply("unlock_yld.b1", 0, 1, 1, 0, 1);
      apply("unlock_yld.b2", 0, 1, 1, 0, 1);
      apply("unlock_yld.exit", 1, 1, 0, 0, 1);
      apply("unlock_yld.yield", 1, 1, 0, 1, 0);
      apply("idle", 0, 0, 0, 0, 0);

      // reset mid-burst with a DMA read in flight
      dma_addr = 8'h10;
      apply("rst_burst.b1", 0, 1, 1, 0, 1);
      apply("rst_burst.b2", 0, 1, 1, 0, 1);
      reset = 1'b1; cpu_req = 1;
      tick();
      reset = 1'b0;
      at_neg();
      check("rst_burst.dma_rvalid", dma_rvalid, 1'b0);
      check("rst_burst.dma_rdata", dma_rdata, 8'h00);
      check("rst_burst.cpu_gnt", cpu_gnt, 1'b1);
      check("rst_burst.dma_gnt", dma_gnt, 1'b0);
      tick();
      cpu_req = 0; dma_req = 0; dma_lock = 0;
      tick();

`ifdef ARB_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cpu_req = 1; dma_req = 1; dma_lock = 0;
      for (int i = 0; i < 40; i++) tick();
      cpu_req = 0; dma_req = 0;
      at_neg();
      check("stats.stall10", cpu_stall_count, 16'd10);
      check("stats.dgnt10", dma_grant_count, 16'd10);
      tick();
      quiet = 1'b1;
      dma_req = 1;
      for (int i = 0; i < 65540; i++) tick();
      dma_req = 0;
      at_neg();
      check("stats.dgnt_sat", dma_grant_count, 16'hFFFF);
      tick();
      quiet = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
